mining_scheduler: RTL

//  Job sequencer for an array of NUM_CORES sha_core instances. Accepts a mining job, holds

---
 rtl/mining_pkg.sv | 11 +
 rtl/pending_picker.sv | 25 ++
 rtl/mining_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mining_pkg.sv
// Shared constants and types for the mining job scheduler.
package mining_pkg;
  localparam int CYCLES_PER_HASH = 64;
  localparam int CORE_OUT_W      = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;
endpackage

// File: rtl/pending_picker.sv
// Lowest-set-bit priority encoder over the pending winner mask.
module pending_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // scan high to low so the lowest set bit wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mining_scheduler.sv
// Job sequencer for the sha_core array: steps round counter and nonce base,
// samples core flags once per pass and queues winning nonces to the host.
module mining_scheduler
  import mining_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int CHECK_CYCLE = 63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [255:0]                  job_midstate,
  input  logic [511:0]                  job_head,
  input  logic [31:0]                   job_nonce_start,
  input  logic [31:0]                   job_nonce_end,
  input  logic                          abort,
  output logic [255:0]                  core_midstate,
  output logic [511:0]                  core_head,
  output logic [5:0]                    core_cycle,
  output logic [31:0]                   core_nonce,
  input  logic [CORE_OUT_W*NUM_CORES-1:0] core_result,
  output logic                          found_valid,
  input  logic                          found_ready,
  output logic [31:0]                   found_nonce,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CYC_W = $clog2(CYCLES_PER_HASH);
  localparam logic [NUM_CORES-1:0] ONE_MASK = {{(NUM_CORES-1){1'b0}}, 1'b1};

  sched_state_t            state_r;
  logic                    job_ready_r, busy_r, done_r, found_valid_r, last_pass_r;
  logic [31:0]             found_nonce_r, core_nonce_r, end_r, base_r;
  logic [255:0]            core_midstate_r;
  logic [511:0]            core_head_r;
  logic [CYC_W-1:0]        core_cycle_r;
  logic [NUM_CORES-1:0]    pending_r, pending_next_s, hit_s;
  logic [IDX_W-1:0]        found_idx_r, pick_idx_s;
  logic                    pick_any_s, sample_s, handshake_s, last_now_s;
  logic                    unused_nonce_s;

  assign sample_s    = (state_r == RUN) && (core_cycle_r == CYC_W'(CHECK_CYCLE));
  assign handshake_s = (state_r == DRAIN) && found_valid_r && found_ready;
  // 33-bit compares so a range ending at 0xFFFFFFFF never wraps
  assign last_now_s  = ({1'b0, core_nonce_r} + 33'(NUM_CORES - 1)) >= {1'b0, end_r};

  // flag qualification: only nonces inside the job range count
  always_comb begin
    hit_s          = '0;
    unused_nonce_s = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      hit_s[i] = core_result[CORE_OUT_W*i + 32] &
                 (({1'b0, core_nonce_r} + 33'(i)) <= {1'b0, end_r});
      unused_nonce_s = unused_nonce_s ^ (^core_result[CORE_OUT_W*i +: 32]);
    end
  end

  // next pending mask: load at the check cycle, retire one bit per handshake
  always_comb begin
    pending_next_s = pending_r;
    if (sample_s) begin
      pending_next_s = hit_s;
    end else if (handshake_s) begin
      pending_next_s = pending_r & ~(ONE_MASK << found_idx_r);
    end else begin
      pending_next_s = pending_r;
    end
  end

  pending_picker #(.N(NUM_CORES), .IDX_W(IDX_W)) u_picker (
    .req (pending_next_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      job_ready_r     <= 1'b1;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      found_valid_r   <= 1'b0;
      found_nonce_r   <= 32'd0;
      found_idx_r     <= '0;
      core_midstate_r <= 256'd0;
      core_head_r     <= 512'd0;
      core_cycle_r    <= '0;
      core_nonce_r    <= 32'd0;
      end_r           <= 32'd0;
      base_r          <= 32'd0;
      last_pass_r     <= 1'b0;
      pending_r       <= '0;
    end else if (abort) begin
      state_r       <= IDLE;
      job_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      found_valid_r <= 1'b0;
      pending_r     <= '0;
      core_cycle_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (job_valid) begin
            core_midstate_r <= job_midstate;
            core_head_r     <= job_head;
            end_r           <= job_nonce_end;
            core_nonce_r    <= job_nonce_start;
            core_cycle_r    <= '0;
            job_ready_r     <= 1'b0;
            busy_r          <= 1'b1;
            state_r         <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          pending_r <= pending_next_s;
          if (sample_s) begin
            base_r       <= core_nonce_r;
            last_pass_r  <= last_now_s;
            core_cycle_r <= '0;
            if (pick_any_s) begin
              state_r       <= DRAIN;
              found_valid_r <= 1'b1;
              found_idx_r   <= pick_idx_s;
              found_nonce_r <= core_nonce_r + 32'(pick_idx_s);
            end else if (last_now_s) begin
              state_r     <= IDLE;
              done_r      <= 1'b1;
              job_ready_r <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              core_nonce_r <= core_nonce_r + 32'(NUM_CORES);
            end
          end else begin
            core_cycle_r <= core_cycle_r + CYC_W'(1);
          end
        end
        DRAIN: begin
          pending_r <= pending_next_s;
          if (handshake_s) begin
            if (pick_any_s) begin
              found_idx_r   <= pick_idx_s;
              found_nonce_r <= base_r + 32'(pick_idx_s);
            end else begin
              found_valid_r <= 1'b0;
              core_cycle_r  <= '0;
              if (last_pass_r) begin
                state_r     <= IDLE;
                done_r      <= 1'b1;
                job_ready_r <= 1'b1;
                busy_r      <= 1'b0;
              end else begin
                state_r      <= RUN;
                core_nonce_r <= core_nonce_r + 32'(NUM_CORES);
              end
            end
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r       <= IDLE;
          job_ready_r   <= 1'b1;
          busy_r        <= 1'b0;
          found_valid_r <= 1'b0;
          pending_r     <= '0;
        end
      endcase
    end
  end

  assign job_ready     = job_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign found_valid   = found_valid_r;
  assign found_nonce   = found_nonce_r;
  assign core_midstate = core_midstate_r;
  assign core_head     = core_head_r;
  assign core_cycle    = core_cycle_r;
  assign core_nonce    = core_nonce_r;

endmodule
